// File: rtl/invtran_sched.sv
// rtl/invtran_sched.sv - round-robin, credit-gated scheduler for a shared 4x4 inverse transform core
module invtran_sched #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int CORE_LAT  = 2,
    parameter int OUT_DEPTH = 4,
    parameter int PTR_W     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               core_en,
    output logic [ID_W-1:0]    core_sel,
    output logic               cap_en,
    output logic [PTR_W-1:0]   cap_ptr,
    output logic [ID_W-1:0]    cap_id,
    output logic               res_valid,
    output logic [ID_W-1:0]    res_id,
    output logic [PTR_W-1:0]   res_ptr,
    input  logic               res_ready,
    output logic               busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FULL} state_t;

    logic [CORE_LAT-1:0] pipe_v_q;
    logic [ID_W-1:0]     pipe_id_q [CORE_LAT];
    logic [ID_W-1:0]     id_fifo_q [OUT_DEPTH];
    logic [PTR_W:0]      count_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [ID_W-1:0]     rr_ptr_q;
    state_t              state_q;

    logic [PTR_W:0]      inflight;
    logic [PTR_W:0]      inflight_d;
    logic [PTR_W:0]      count_d;
    logic [PTR_W+1:0]    occ;
    logic [PTR_W+1:0]    occ_d;
    logic                credit_ok;
    logic [NUM_REQ-1:0]  grant_vec;
    logic [ID_W-1:0]     grant_id;
    logic                issue;
    logic                pop;
    state_t              state_d;

    // Blocks still travelling through the core: one per valid pipe stage.
    always_comb begin
        inflight = '0;
        for (int s = 0; s < CORE_LAT; s++) begin
            inflight = inflight + {{PTR_W{1'b0}}, pipe_v_q[s]};
        end
    end

    // Only issue when the buffer can absorb every block already committed to the core.
    assign occ       = {1'b0, inflight} + {1'b0, count_q};
    assign credit_ok = occ < (PTR_W+2)'(OUT_DEPTH);

    // Round-robin search starting at rr_ptr_q, first valid requester wins.
    always_comb begin
        logic [ID_W:0] idx;
        logic          found;
        grant_vec = '0;
        grant_id  = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found                      = 1'b1;
                grant_vec[idx[ID_W-1:0]]   = 1'b1;
                grant_id                   = idx[ID_W-1:0];
            end
        end
    end

    // Grant is suppressed while reset is held so no handshake can complete.
    assign req_ready = grant_vec & {NUM_REQ{credit_ok & reset}};
    assign issue     = |(req_valid & req_ready);
    assign core_en   = issue;
    assign core_sel  = issue ? grant_id : '0;

    assign cap_en    = pipe_v_q[CORE_LAT-1];
    assign cap_id    = pipe_id_q[CORE_LAT-1];
    assign cap_ptr   = wr_ptr_q;

    assign res_valid = (count_q != '0);
    assign res_ptr   = rd_ptr_q;
    assign res_id    = id_fifo_q[rd_ptr_q];
    assign pop       = res_valid & res_ready;

    assign inflight_d = inflight + {{PTR_W{1'b0}}, issue} - {{PTR_W{1'b0}}, cap_en};
    assign count_d    = count_q + {{PTR_W{1'b0}}, cap_en} - {{PTR_W{1'b0}}, pop};
    assign occ_d      = {1'b0, inflight_d} + {1'b0, count_d};

    // State follows the occupancy the pipe and buffer will have next cycle.
    always_comb begin
        state_d = ST_RUN;
        if (inflight_d == '0 && count_d == '0) begin
            state_d = ST_IDLE;
        end else if (occ_d >= (PTR_W+2)'(OUT_DEPTH)) begin
            state_d = ST_FULL;
        end
    end

    assign busy = (state_q != ST_IDLE);

    // Latency pipe, result-buffer pointers, id FIFO, arbiter pointer and state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_v_q <= '0;
            for (int s = 0; s < CORE_LAT; s++) begin
                pipe_id_q[s] <= '0;
            end
            for (int e = 0; e < OUT_DEPTH; e++) begin
                id_fifo_q[e] <= '0;
            end
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_ptr_q <= '0;
            state_q  <= ST_IDLE;
        end else begin
            pipe_v_q[0]  <= issue;
            pipe_id_q[0] <= core_sel;
            for (int s = 1; s < CORE_LAT; s++) begin
                pipe_v_q[s]  <= pipe_v_q[s-1];
                pipe_id_q[s] <= pipe_id_q[s-1];
            end
            if (cap_en) begin
                id_fifo_q[wr_ptr_q] <= cap_id;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (issue) begin
                rr_ptr_q <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
            end
            count_q <= count_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_invtran_sched.sv
// tb/tb_invtran_sched.sv - directed self-checking bench for invtran_sched
module tb_invtran_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic       core_en;
    logic [1:0] core_sel;
    logic       cap_en;
    logic [1:0] cap_ptr;
    logic [1:0] cap_id;
    logic       res_valid;
    logic [1:0] res_id;
    logic [1:0] res_ptr;
    logic       res_ready;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    invtran_sched #(
        .NUM_REQ(4), .ID_W(2), .CORE_LAT(2), .OUT_DEPTH(4), .PTR_W(2)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .core_en(core_en), .core_sel(core_sel),
        .cap_en(cap_en), .cap_ptr(cap_ptr), .cap_id(cap_id),
        .res_valid(res_valid), .res_id(res_id), .res_ptr(res_ptr),
        .res_ready(res_ready), .busy(busy)
    );

    // Buffer occupancy must never exceed its depth.
    always @(negedge clk) begin
        if (reset) begin
            vectors++;
            if (dut.count_q > 3'd4) begin
                miscompares++;
                $display("FAIL occupancy got=%0d exp<=4", dut.count_q);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = 4'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        vectors++;
        if ({req_ready, core_en, core_sel, cap_en, cap_ptr, cap_id, res_valid, res_id, res_ptr, busy} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {req_ready, core_en, core_sel, cap_en, cap_ptr, cap_id, res_valid, res_id, res_ptr, busy});
        end
        do_reset();
    endtask

    task automatic test_single_block();
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        vectors++;
        if ({req_ready, core_en, core_sel} !== {4'b0001, 1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL single_issue got=%b exp=%b", {req_ready, core_en, core_sel}, {4'b0001, 1'b1, 2'd0});
        end
        nxt();
        req_valid = 4'b0;
        #1;
        vectors++;
        if ({cap_en, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL single_c1 got=%b exp=01", {cap_en, busy});
        end
        nxt();
        vectors++;
        if ({cap_en, cap_id, cap_ptr, res_valid} !== {1'b1, 2'd0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL single_cap got=%b exp=100000", {cap_en, cap_id, cap_ptr, res_valid});
        end
        nxt();
        vectors++;
        if ({res_valid, res_id, res_ptr, busy} !== {1'b1, 2'd0, 2'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL single_res got=%b exp=100001", {res_valid, res_id, res_ptr, busy});
        end
        nxt();
        vectors++;
        if ({res_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_idle got=%b exp=00", {res_valid, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] er;
        logic [1:0] es;
        logic [1:0] ec;
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            #1;
            er = 4'b0001 << (i % 4);
            es = 2'(i % 4);
            vectors++;
            if ({req_ready, core_en, core_sel} !== {er, 1'b1, es}) begin
                miscompares++;
                $display("FAIL b2b_grant[%0d] got=%b exp=%b", i, {req_ready, core_en, core_sel}, {er, 1'b1, es});
            end
            if (i >= 2) begin
                ec = 2'((i - 2) % 4);
                vectors++;
                if ({cap_en, cap_id, cap_ptr} !== {1'b1, ec, ec}) begin
                    miscompares++;
                    $display("FAIL b2b_cap[%0d] got=%b exp=%b", i, {cap_en, cap_id, cap_ptr}, {1'b1, ec, ec});
                end
            end
            nxt();
        end
        req_valid = 4'b0;
        repeat (5) nxt();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain got=%b exp=0", busy);
        end
    endtask

    task automatic test_full_credit();
        logic [3:0] er;
        do_reset();
        res_ready = 1'b0;
        req_valid = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            #1;
            er = (i % 2 == 1) ? 4'b0010 : 4'b0001;
            vectors++;
            if ({req_ready, core_en} !== {er, 1'b1}) begin
                miscompares++;
                $display("FAIL full_issue[%0d] got=%b exp=%b", i, {req_ready, core_en}, {er, 1'b1});
            end
            nxt();
        end
        for (int i = 4; i < 8; i++) begin
            #1;
            vectors++;
            if ({req_ready, core_en, busy} !== {4'b0000, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL full_block[%0d] got=%b exp=000001", i, {req_ready, core_en, busy});
            end
            nxt();
        end
        vectors++;
        if ({res_valid, res_id, res_ptr, dut.count_q} !== {1'b1, 2'd0, 2'd0, 3'd4}) begin
            miscompares++;
            $display("FAIL full_state got=%b exp=%b", {res_valid, res_id, res_ptr, dut.count_q}, {1'b1, 2'd0, 2'd0, 3'd4});
        end
        res_ready = 1'b1;
        #1;
        vectors++;
        if ({req_ready, res_valid} !== 5'b00001) begin
            miscompares++;
            $display("FAIL full_pop_cycle got=%b exp=00001", {req_ready, res_valid});
        end
        nxt();
        res_ready = 1'b0;
        #1;
        vectors++;
        if ({req_ready, core_en, core_sel, res_id, res_ptr} !== {4'b0001, 1'b1, 2'd0, 2'd1, 2'd1}) begin
            miscompares++;
            $display("FAIL full_reissue got=%b exp=%b", {req_ready, core_en, core_sel, res_id, res_ptr},
                     {4'b0001, 1'b1, 2'd0, 2'd1, 2'd1});
        end
        nxt();
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL full_again got=%b exp=0000", req_ready);
        end
        req_valid = 4'b0;
        res_ready = 1'b1;
        repeat (8) nxt();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_drain got=%b exp=0", busy);
        end
    endtask

    task automatic test_cap_pop_wrap();
        do_reset();
        res_ready = 1'b0;
        req_valid = 4'b0100;
        #1;
        vectors++;
        if ({core_en, core_sel} !== 3'b110) begin
            miscompares++;
            $display("FAIL wrap_i0 got=%b exp=110", {core_en, core_sel});
        end
        nxt();
        req_valid = 4'b1000;
        #1;
        vectors++;
        if ({core_en, core_sel} !== 3'b111) begin
            miscompares++;
            $display("FAIL wrap_i1 got=%b exp=111", {core_en, core_sel});
        end
        nxt();
        req_valid = 4'b0010;
        #1;
        vectors++;
        if ({core_en, core_sel, cap_en, cap_id, cap_ptr} !== {1'b1, 2'd1, 1'b1, 2'd2, 2'd0}) begin
            miscompares++;
            $display("FAIL wrap_c2 got=%b exp=%b", {core_en, core_sel, cap_en, cap_id, cap_ptr}, {1'b1, 2'd1, 1'b1, 2'd2, 2'd0});
        end
        nxt();
        req_valid = 4'b0001;
        res_ready = 1'b1;
        #1;
        vectors++;
        if ({core_sel, res_valid, res_id, res_ptr, cap_en, cap_id, cap_ptr} !==
            {2'd0, 1'b1, 2'd2, 2'd0, 1'b1, 2'd3, 2'd1}) begin
            miscompares++;
            $display("FAIL wrap_c3 got=%b exp=%b", {core_sel, res_valid, res_id, res_ptr, cap_en, cap_id, cap_ptr},
                     {2'd0, 1'b1, 2'd2, 2'd0, 1'b1, 2'd3, 2'd1});
        end
        nxt();
        req_valid = 4'b0100;
        #1;
        vectors++;
        if ({core_sel, res_valid, res_id, res_ptr, dut.count_q, cap_id, cap_ptr} !==
            {2'd2, 1'b1, 2'd3, 2'd1, 3'd1, 2'd1, 2'd2}) begin
            miscompares++;
            $display("FAIL wrap_c4 got=%b exp=%b", {core_sel, res_valid, res_id, res_ptr, dut.count_q, cap_id, cap_ptr},
                     {2'd2, 1'b1, 2'd3, 2'd1, 3'd1, 2'd1, 2'd2});
        end
        nxt();
        req_valid = 4'b0;
        #1;
        vectors++;
        if ({res_id, res_ptr, cap_en, cap_id, cap_ptr} !== {2'd1, 2'd2, 1'b1, 2'd0, 2'd3}) begin
            miscompares++;
            $display("FAIL wrap_c5 got=%b exp=%b", {res_id, res_ptr, cap_en, cap_id, cap_ptr}, {2'd1, 2'd2, 1'b1, 2'd0, 2'd3});
        end
        nxt();
        vectors++;
        if ({res_id, res_ptr, cap_en, cap_id, cap_ptr} !== {2'd0, 2'd3, 1'b1, 2'd2, 2'd0}) begin
            miscompares++;
            $display("FAIL wrap_c6 got=%b exp=%b", {res_id, res_ptr, cap_en, cap_id, cap_ptr}, {2'd0, 2'd3, 1'b1, 2'd2, 2'd0});
        end
        nxt();
        vectors++;
        if ({res_valid, res_id, res_ptr} !== {1'b1, 2'd2, 2'd0}) begin
            miscompares++;
            $display("FAIL wrap_c7 got=%b exp=11000", {res_valid, res_id, res_ptr});
        end
        nxt();
        vectors++;
        if ({res_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL wrap_c8 got=%b exp=00", {res_valid, busy});
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        res_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (4) nxt();
        vectors++;
        if ({req_ready, res_valid, cap_en, busy} !== {4'b0000, 3'b111}) begin
            miscompares++;
            $display("FAIL midop_pre got=%b exp=0000111", {req_ready, res_valid, cap_en, busy});
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({req_ready, core_en, core_sel, cap_en, cap_ptr, cap_id, res_valid, res_id, res_ptr, busy} !== 19'd0) begin
            miscompares++;
            $display("FAIL midop_async got=%h exp=0",
                     {req_ready, core_en, core_sel, cap_en, cap_ptr, cap_id, res_valid, res_id, res_ptr, busy});
        end
        nxt();
        reset     = 1'b1;
        req_valid = 4'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if ({cap_en, res_valid, busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL midop_after[%0d] got=%b exp=000", i, {cap_en, res_valid, busy});
            end
            nxt();
        end
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL midop_first_grant got=%b exp=0001", req_ready);
        end
        nxt();
        req_valid = 4'b0;
        res_ready = 1'b1;
        repeat (5) nxt();
    endtask

    task automatic test_rr_wrap_drop();
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL rr_first got=%b exp=0100", req_ready);
        end
        nxt();
        #1;
        vectors++;
        if ({req_ready, core_sel} !== {4'b0100, 2'd2}) begin
            miscompares++;
            $display("FAIL rr_wrap got=%b exp=010010", {req_ready, core_sel});
        end
        nxt();
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL rr_ptr3 got=%b exp=1000", req_ready);
        end
        nxt();
        req_valid = 4'b0011;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL rr_after_wrap got=%b exp=0001", req_ready);
        end
        nxt();
        req_valid = 4'b0001;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL rr_dropped got=%b exp=0001", req_ready);
        end
        nxt();
        req_valid = 4'b0;
        repeat (6) nxt();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_drain got=%b exp=0", busy);
        end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 4'b0;
        res_ready = 1'b0;
        test_reset();
        test_single_block();
        test_back_to_back();
        test_full_credit();
        test_cap_pop_wrap();
        test_reset_midop();
        test_rr_wrap_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
